usb_key_report_parser: RTL and testbench
========================================

# usb_key_report_parser

- Converts the raw keyboard HID boot-report byte stream from the USB host interface into the two keycode registers read by the sprite and motion logic.
- Both `keycode` and `keycode2` are consumed by the Mario animation FSM and the movement controller.
- Accepts bytes over a valid/ready handshake, validates report framing, and extracts the first two non-zero key slots.
- Publishes a new key state atomically, once per well-formed report.

## Interface
Parameters:
- REPORT_LEN, 8, bytes per report; byte 0 = modifiers, byte 1 = reserved, bytes 2..REPORT_LEN-1 = key slots.
- KEY_FIRST, 2, index of the first key slot.

Ports:
- Clk  in  1  system clock; all logic is synchronous to its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- byte_data  in  8  report byte.
- byte_valid  in  1  byte_data is valid.
- byte_last  in  1  the current byte is the final byte of the report.
- byte_ready  out  1  parser can accept a byte; a transfer occurs when byte_valid && byte_ready on a rising edge.
- keycode  out  8  first non-zero key slot of the last committed report.
- keycode2  out  8  second non-zero key slot of the last committed report.
- modifiers  out  8  byte 0 of the last committed report.
- report_strobe  out  1  one-cycle pulse when the outputs are updated.
- frame_err  out  1  one-cycle pulse when a report is discarded.

Reset and clocking (already decided): one clock `Clk`; reset `Reset_n` is asynchronous and active-low.

## Operation
FSM states: IDLE, COLLECT, COMMIT, DISCARD.

Byte index:
- Counter `idx`, 4 bits, cleared in IDLE.
- Incremented on every accepted byte.

Shadow registers:
- `mod_s`, `k1_s`, `k2_s` are cleared on the first accepted byte of each report.
- Byte 0 is loaded into `mod_s`.
- Byte at index ≥ KEY_FIRST and ≠ 0x00:
  - loads `k1_s` if `k1_s` is still empty;
  - otherwise loads `k2_s` if `k2_s` is still empty;
  - otherwise is ignored.
- Byte 1 is ignored.

Transitions:
- IDLE → COLLECT on the first accepted byte; IDLE also handles byte 0 itself.
- COLLECT, byte accepted with byte_last=1:
  - idx == REPORT_LEN-1 → COMMIT;
  - idx < REPORT_LEN-1 → IDLE, with frame_err pulsed (short report).
- COLLECT, byte accepted at idx == REPORT_LEN-1 with byte_last=0 → DISCARD (long report).
- DISCARD drops bytes until one is accepted with byte_last=1, then → IDLE with frame_err pulsed.
- COMMIT → IDLE unconditionally after one cycle. On that edge the shadow registers are copied to the outputs and report_strobe is pulsed.

Framing rules:
- A byte_last on byte 0 is a short report.
- Outputs never change on a discarded report; they hold their previous values.
- Keycode order follows slot order. Duplicate non-zero codes are taken as they come; no deduplication is performed.

## Timing
- Reset values: keycode=0x00, keycode2=0x00, modifiers=0x00, report_strobe=0, frame_err=0, byte_ready=1, state=IDLE.
- Reset asserted mid-report aborts the report with no strobe and no error. The first byte after reset release is treated as byte 0.
- byte_ready=0 only in COMMIT, so exactly one bubble follows each good report. It is 1 in all other states, including DISCARD.
- Latency: if the last byte is accepted at edge N, outputs change and report_strobe=1 after edge N+1, for exactly one cycle.
- frame_err is asserted for the one cycle following the edge that accepted the offending byte_last.
- Back-to-back reports sustain REPORT_LEN+1 cycles per report.

## Configuration
Macro: `KEYPARSE_ROLLOVER_HOLD_EN`.
- Defined:
  - a report whose key slots are all 0x01 (ErrorRollOver) is treated as a phantom state;
  - COMMIT updates `modifiers` only and still pulses report_strobe;
  - keycode and keycode2 keep their previous values, so the sprite FSM does not drop to standing.
- Undefined: 0x01 is handled as an ordinary non-zero code, giving keycode=0x01 and keycode2=0x01.

## Test plan
- Reset release, then report 00 00 04 00 00 00 00 00 (last on byte 7) → report_strobe after edge N+1; keycode=0x04, keycode2=0x00, modifiers=0x00.
- Report 02 00 00 07 00 04 16 00 → keycode=0x07, keycode2=0x04, modifiers=0x02; byte 0x16 is ignored. byte_ready=0 for exactly one cycle after byte 7.
- Short report 00 00 04 with byte_last on byte 2 → frame_err for one cycle, no strobe, keycode keeps its prior value. The next 8-byte report parses correctly.
- 10-byte report with byte_last on byte 9 → DISCARD entered after byte 7; one frame_err after byte 9; outputs unchanged.
- Reset_n pulled low after byte 4 of a report containing 0x07 → outputs 0x00 immediately, no strobe. A following clean report with 0x04 gives keycode=0x04.
- Report 00 00 01 01 01 01 01 01 after a report with 0x04:
  - with the macro defined → keycode stays 0x04, strobe=1;
  - without the macro → keycode=0x01, keycode2=0x01.

Source files
------------

// File: rtl/usb_key_report_parser.sv
// Turns a HID boot-report byte stream into modifier and keycode registers, updated once per good report.
// Optional build macro KEYPARSE_ROLLOVER_HOLD_EN: an all-ErrorRollOver report updates modifiers only.
module usb_key_report_parser #(
    parameter int REPORT_LEN = 8,
    parameter int KEY_FIRST  = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic [7:0] keycode,
    output logic [7:0] keycode2,
    output logic [7:0] modifiers,
    output logic       report_strobe,
    output logic       frame_err
);

    // state   | meaning
    // IDLE    | waiting for byte 0; consumes it and clears the shadows
    // COLLECT | consuming bytes 1..REPORT_LEN-1 into the shadows
    // COMMIT  | one-cycle bubble; shadows copied to the outputs
    // DISCARD | over-long report, dropping bytes until byte_last
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(REPORT_LEN - 1);
    localparam logic [3:0] KEY_IDX  = 4'(KEY_FIRST);

    state_t     state, state_nxt;
    logic [3:0] idx;
    logic [7:0] mod_s, k1_s, k2_s;
    logic       err_nxt;
    logic       accept;

    assign byte_ready = (state != COMMIT);
    assign accept     = byte_valid && byte_ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (byte_last) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (byte_last) begin
                        if (idx == LAST_IDX) begin
                            state_nxt = COMMIT;
                        end else begin
                            state_nxt = IDLE;
                            err_nxt   = 1'b1;
                        end
                    end else if (idx == LAST_IDX) begin
                        state_nxt = DISCARD;
                    end
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            DISCARD: begin
                if (accept && byte_last) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef KEYPARSE_ROLLOVER_HOLD_EN
    // Stays set while every key slot seen so far is ErrorRollOver (0x01).
    logic roll_s;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx   <= 4'd0;
            mod_s <= 8'h00;
            k1_s  <= 8'h00;
            k2_s  <= 8'h00;
`ifdef KEYPARSE_ROLLOVER_HOLD_EN
            roll_s <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx   <= 4'd1;
                        mod_s <= byte_data;
                        k1_s  <= 8'h00;
                        k2_s  <= 8'h00;
`ifdef KEYPARSE_ROLLOVER_HOLD_EN
                        roll_s <= 1'b1;
`endif
                    end else begin
                        idx <= 4'd0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        idx <= idx + 4'd1;
                        if (idx >= KEY_IDX) begin
                            if (byte_data != 8'h00) begin
                                if (k1_s == 8'h00) begin
                                    k1_s <= byte_data;
                                end else if (k2_s == 8'h00) begin
                                    k2_s <= byte_data;
                                end
                            end
`ifdef KEYPARSE_ROLLOVER_HOLD_EN
                            if (byte_data != 8'h01) begin
                                roll_s <= 1'b0;
                            end
`endif
                        end
                    end
                end
                default: begin
                    idx <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            keycode       <= 8'h00;
            keycode2      <= 8'h00;
            modifiers     <= 8'h00;
            report_strobe <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            report_strobe <= (state == COMMIT);
            frame_err     <= err_nxt;
            if (state == COMMIT) begin
                modifiers <= mod_s;
`ifdef KEYPARSE_ROLLOVER_HOLD_EN
                if (!roll_s) begin
                    keycode  <= k1_s;
                    keycode2 <= k2_s;
                end
`else
                keycode  <= k1_s;
                keycode2 <= k2_s;
`endif
            end
        end
    end

endmodule

// File: tb/tb_usb_key_report_parser.sv
// Self-checking bench for usb_key_report_parser: directed reports plus random framing against a report-level model.
module tb_usb_key_report_parser;

    localparam int REPORT_LEN = 8;
    localparam int KEY_FIRST  = 2;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic [7:0] keycode;
    logic [7:0] keycode2;
    logic [7:0] modifiers;
    logic       report_strobe;
    logic       frame_err;

    usb_key_report_parser #(
        .REPORT_LEN(REPORT_LEN),
        .KEY_FIRST (KEY_FIRST)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .keycode      (keycode),
        .keycode2     (keycode2),
        .modifiers    (modifiers),
        .report_strobe(report_strobe),
        .frame_err    (frame_err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_key, exp_key2, exp_mod;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Report-level model: a report commits only if it is exactly REPORT_LEN bytes long.
    task automatic model_report(input logic [7:0] q[$], output bit good);
        logic [7:0] nz[$];
        bit all_roll;
        good = (q.size() == REPORT_LEN);
        if (!good) return;
        all_roll = 1'b1;
        for (int i = KEY_FIRST; i < q.size(); i++) begin
            if (q[i] != 8'h00) nz.push_back(q[i]);
            if (q[i] != 8'h01) all_roll = 1'b0;
        end
        exp_mod = q[0];
`ifdef KEYPARSE_ROLLOVER_HOLD_EN
        if (all_roll) return;
`endif
        exp_key  = (nz.size() > 0) ? nz[0] : 8'h00;
        exp_key2 = (nz.size() > 1) ? nz[1] : 8'h00;
    endtask

    // Entered and left at a falling edge.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int waited = 0;
        while (!byte_ready && waited < 8) begin
            byte_valid = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            waited++;
        end
        if (!byte_ready) check_val("ready_timeout", 32'(byte_ready), 32'd1);
        byte_data  = d;
        byte_valid = 1'b1;
        byte_last  = last;
        @(posedge Clk);
        @(negedge Clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_key"},  32'(keycode),   32'(exp_key));
        check_val({tag, "_key2"}, 32'(keycode2),  32'(exp_key2));
        check_val({tag, "_mod"},  32'(modifiers), 32'(exp_mod));
    endtask

    task automatic run_report(input logic [7:0] q[$], input bit gaps, input string tag);
        bit good;
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge Clk);
                @(negedge Clk);
            end
            send_byte(q[i], i == q.size() - 1);
        end
        model_report(q, good);
        if (good) begin
            check_val({tag, "_bubble"}, 32'(byte_ready), 32'd0);
            check_val({tag, "_strobe_early"}, 32'(report_strobe), 32'd0);
            @(posedge Clk);
            @(negedge Clk);
            check_val({tag, "_strobe"}, 32'(report_strobe), 32'd1);
            check_val({tag, "_ready_back"}, 32'(byte_ready), 32'd1);
            check_val({tag, "_no_err"}, 32'(frame_err), 32'd0);
        end else begin
            check_val({tag, "_frame_err"}, 32'(frame_err), 32'd1);
            check_val({tag, "_no_strobe"}, 32'(report_strobe), 32'd0);
            check_val({tag, "_ready"}, 32'(byte_ready), 32'd1);
            @(posedge Clk);
            @(negedge Clk);
            check_val({tag, "_err_pulse"}, 32'(frame_err), 32'd0);
            check_val({tag, "_no_strobe2"}, 32'(report_strobe), 32'd0);
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] q[$];
        Reset_n    = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        exp_key    = 8'h00;
        exp_key2   = 8'h00;
        exp_mod    = 8'h00;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_val("rst_ready", 32'(byte_ready), 32'd1);
        check_val("rst_strobe", 32'(report_strobe), 32'd0);
        check_val("rst_err", 32'(frame_err), 32'd0);
        check_outputs("rst");

        q = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_report(q, 1'b0, "first");
        q = '{8'h02, 8'h00, 8'h00, 8'h07, 8'h00, 8'h04, 8'h16, 8'h00};
        run_report(q, 1'b0, "two_keys");
        q = '{8'h00, 8'h00, 8'h04};
        run_report(q, 1'b0, "short");
        q = '{8'h11};
        run_report(q, 1'b0, "short_b0");
        q = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
        run_report(q, 1'b0, "after_short");
        q = '{8'h00, 8'h00, 8'h09, 8'h0a, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0b, 8'h0c};
        run_report(q, 1'b0, "long");

        // Reset in the middle of a report.
        q = '{8'h00, 8'h00, 8'h07, 8'h00, 8'h00};
        foreach (q[i]) send_byte(q[i], 1'b0);
        Reset_n = 1'b0;
        #1;
        exp_key  = 8'h00;
        exp_key2 = 8'h00;
        exp_mod  = 8'h00;
        check_outputs("mid_rst");
        check_val("mid_rst_strobe", 32'(report_strobe), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_val("mid_rst_err", 32'(frame_err), 32'd0);
        q = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_report(q, 1'b0, "post_rst");
        q = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        run_report(q, 1'b0, "rollover");
        q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h2c, 8'h2c, 8'h00, 8'h00};
        run_report(q, 1'b0, "dup_keys");

        for (int r = 0; r < 60; r++) begin
            int len;
            int sel;
            bit roll;
            q.delete();
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       len = REPORT_LEN;
            else if (sel == 7) len = int'($urandom_range(1, REPORT_LEN - 1));
            else               len = int'($urandom_range(REPORT_LEN + 1, REPORT_LEN + 4));
            roll = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < len; i++) begin
                if (i < KEY_FIRST)                   q.push_back(8'($urandom));
                else if (roll)                       q.push_back(8'h01);
                else if ($urandom_range(0, 2) == 0)  q.push_back(8'($urandom));
                else                                 q.push_back(8'h00);
            end
            run_report(q, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
